msx_io_bus: RTL and testbench
=============================

Name: msx_io_bus

Overview:
Parametrised Z80 I/O-port decoder, wait-state generator and read-data mux for MSX-family cores. It replaces the single hard-wired VDP port decode in the machine top level. It serves NUM_DEV peripherals (VDP, PSG, PPI, RTC, ...), each with a runtime base/mask. It issues one-cycle chip-select strobes, inserts per-device wait states, and registers read data until the I/O cycle ends.

Parameters:
NUM_DEV, 4, number of decoded peripherals (1..16)
WAIT_W, 4, width of the per-device wait-state count in CPU clock-enable ticks

Ports:
clk21m  in  1  system clock
reset  in  1  synchronous, active-high reset
ce_3m58  in  1  CPU clock enable; the wait counter decrements only on this enable
addr  in  8  low CPU address byte
d_from_cpu  in  8  CPU write data (passed through, not registered)
wr_n  in  1  CPU write strobe
rd_n  in  1  CPU read strobe
iorq_n  in  1  CPU I/O request
m1_n  in  1  CPU M1; an I/O cycle with m1_n=0 (interrupt acknowledge) is ignored
dev_base  in  NUM_DEV*8  per-device port base, device i at [8i+7:8i]
dev_mask  in  NUM_DEV*8  per-device compare mask; a 1 bit is compared
dev_wait  in  NUM_DEV*WAIT_W  per-device wait-state count
dev_rd_data  in  NUM_DEV*8  per-device read data
dev_cs_rd  out  NUM_DEV  one-hot, one-clk21m-cycle read strobe
dev_cs_wr  out  NUM_DEV  one-hot, one-clk21m-cycle write strobe
dev_wdata  out  8  equals d_from_cpu
d_to_cpu  out  8  read data to the CPU
dataBusRQ  out  1  high while this block drives d_to_cpu with valid data
wait_n  out  1  CPU WAIT, active low
conflict  out  1  sticky multi-match flag (see Optional Feature)

Behaviour:
- Match rule: device i matches when ((addr ^ base_i) & mask_i) == 0. The lowest matching index wins.
- Cycle start: the cycle starts on the first clk21m edge where iorq_n=0, m1_n=1 and (rd_n=0 or wr_n=0) while in IDLE. If no device matches, the cycle is ignored and the FSM stays in IDLE.
- FSM states: IDLE, WAIT, STROBE, DATA, HOLD.
  - IDLE: on a valid start, latch dev_idx, the direction, and cnt<=dev_wait[dev_idx]. Go to WAIT if cnt≠0, else STROBE.
  - WAIT: wait_n=0. Decrement cnt on each ce_3m58. When cnt reaches 1 and ce_3m58 is high, go to STROBE.
  - STROBE: assert dev_cs_rd[dev_idx] or dev_cs_wr[dev_idx] for exactly one clk21m cycle. Next state is DATA for reads, HOLD for writes.
  - DATA: latch rdata<=dev_rd_data[dev_idx] (one cycle after the strobe), then go to HOLD.
  - HOLD: wait until iorq_n=1, then go to IDLE. At most one strobe is issued per CPU I/O cycle.
- wait_n: 0 from the cycle after start through the end of STROBE (reads: through DATA). It is 1 otherwise. A zero wait count still holds WAIT for the STROBE/DATA cycles.
- d_to_cpu: equals rdata in HOLD for reads; 8'hFF otherwise (including when rd_n=1). dataBusRQ equals (state==HOLD && read && rd_n==0).
- Early abort: if iorq_n deasserts during WAIT, go to IDLE with no strobe, and release wait_n next cycle.
- Reset: applies at any state, including mid-cycle. On reset:
  - state=IDLE, cnt=0, rdata=8'hFF
  - all strobes 0, wait_n=1, d_to_cpu=8'hFF, dataBusRQ=0, conflict=0

Optional Feature:
Macro MSX_IO_CONFLICT_EN.
- Defined: when a cycle starts with more than one device matching, conflict is set and stays 1 until reset. An 8-bit saturating counter, conflict_cnt (internal, visible to the bench via hierarchy), increments once per such cycle and stops at 255.
- Undefined: conflict is tied 0 and no counter logic exists.
- Priority resolution is identical in both builds.

Decomposition:
- Package msx_io_pkg holds:
  - the io_state_t enum (IDLE, WAIT, STROBE, DATA, HOLD)
  - the IDX_W = $clog2(NUM_DEV) helper function
  - the constant IO_IDLE_DATA = 8'hFF
- Sub-module msx_io_match: purely combinational mask compare plus priority encoder. Outputs hit, idx and multi.

Test Plan:
- Read with no wait: NUM_DEV=4, dev0 base 98h mask F8h wait 0, dev_rd_data0=5Ah, CPU IN (99h) → dev_cs_rd[0] is a single pulse; d_to_cpu=5Ah and dataBusRQ=1 in HOLD; wait_n low exactly 2 cycles.
- Write with waits: dev1 base A0h mask FEh wait 3, OUT (A1h),3Ch → wait_n low until 3 ce_3m58 ticks elapse; one dev_cs_wr[1] pulse with dev_wdata=3Ch; no cs_rd.
- Unmapped and M1 cycles: IN (10h) → no strobe, d_to_cpu=FFh, wait_n=1. A cycle with m1_n=0 and iorq_n=0 (INTA) → no activity.
- Overlap: dev2 and dev3 both match 98h → only dev2 strobed. With MSX_IO_CONFLICT_EN: conflict=1, conflict_cnt=1; a second overlap gives 2. Without the macro: conflict=0.
- Abort: iorq_n rises during WAIT → no strobe, FSM returns to IDLE, wait_n=1 next cycle.
- Reset mid-op: reset asserted in WAIT → next edge gives wait_n=1, strobes 0, d_to_cpu=FFh. The following access behaves normally.

Source files
------------

// File: rtl/msx_io_pkg.sv
// Shared types and constants for the MSX I/O port decoder.
package msx_io_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StWait,
      StStrobe,
      StData,
      StHold
   } io_state_t;

   localparam logic [7:0] IO_IDLE_DATA = 8'hFF;

   // Device index width; never zero so a single-device build still has a legal vector.
   function automatic int unsigned idx_w(input int unsigned num_dev);
      return (num_dev > 1) ? $clog2(num_dev) : 1;
   endfunction

endpackage

// File: rtl/msx_io_match.sv
// Combinational base/mask port compare with lowest-index-wins priority encoder.
module msx_io_match #(
   parameter int unsigned NUM_DEV = 4,
   parameter int unsigned IDX_W   = 2
) (
   input  logic [7:0]           addr_i,
   input  logic [NUM_DEV*8-1:0] base_i,
   input  logic [NUM_DEV*8-1:0] mask_i,
   output logic                 hit_o,
   output logic [IDX_W-1:0]     idx_o,
   output logic                 multi_o
);

   logic [NUM_DEV-1:0] match;

   always_comb begin
      match = '0;
      for (int i = 0; i < NUM_DEV; i++) begin
         match[i] = ((addr_i ^ base_i[8*i +: 8]) & mask_i[8*i +: 8]) == 8'h00;
      end
   end

   always_comb begin
      hit_o   = 1'b0;
      idx_o   = '0;
      multi_o = 1'b0;
      for (int i = 0; i < NUM_DEV; i++) begin
         if (match[i]) begin
            if (hit_o) begin
               multi_o = 1'b1;
            end else begin
               hit_o = 1'b1;
               idx_o = IDX_W'(i);
            end
         end
      end
   end

endmodule

// File: rtl/msx_io_bus.sv
// Z80 I/O decoder, wait-state generator and read-data mux for NUM_DEV peripherals.
// Define MSX_IO_CONFLICT_EN to enable the sticky multi-match flag and its counter.
module msx_io_bus
   import msx_io_pkg::*;
#(
   parameter int unsigned NUM_DEV = 4,
   parameter int unsigned WAIT_W  = 4
) (
   input  logic                      clk21m,
   input  logic                      reset,
   input  logic                      ce_3m58,
   input  logic [7:0]                addr,
   input  logic [7:0]                d_from_cpu,
   input  logic                      wr_n,
   input  logic                      rd_n,
   input  logic                      iorq_n,
   input  logic                      m1_n,
   input  logic [NUM_DEV*8-1:0]      dev_base,
   input  logic [NUM_DEV*8-1:0]      dev_mask,
   input  logic [NUM_DEV*WAIT_W-1:0] dev_wait,
   input  logic [NUM_DEV*8-1:0]      dev_rd_data,
   output logic [NUM_DEV-1:0]        dev_cs_rd,
   output logic [NUM_DEV-1:0]        dev_cs_wr,
   output logic [7:0]                dev_wdata,
   output logic [7:0]                d_to_cpu,
   output logic                      dataBusRQ,
   output logic                      wait_n,
   output logic                      conflict
);

   localparam int unsigned IDX_W = idx_w(NUM_DEV);

   io_state_t         state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              rd_q, rd_d;
   logic [WAIT_W-1:0] cnt_q, cnt_d;
   logic [7:0]        rdata_q, rdata_d;

   logic              match_hit;
   logic              match_multi;
   logic [IDX_W-1:0]  match_idx;
   logic              start;
   logic              drive_rd;

   logic [WAIT_W-1:0] wait_arr [NUM_DEV];
   logic [7:0]        rdat_arr [NUM_DEV];

   always_comb begin
      for (int i = 0; i < NUM_DEV; i++) begin
         wait_arr[i] = dev_wait[WAIT_W*i +: WAIT_W];
         rdat_arr[i] = dev_rd_data[8*i +: 8];
      end
   end

   msx_io_match #(
      .NUM_DEV (NUM_DEV),
      .IDX_W   (IDX_W)
   ) u_match (
      .addr_i  (addr),
      .base_i  (dev_base),
      .mask_i  (dev_mask),
      .hit_o   (match_hit),
      .idx_o   (match_idx),
      .multi_o (match_multi)
   );

   // Interrupt acknowledge (M1 low) and unmapped ports never start a cycle.
   assign start = (state_q == StIdle) && !iorq_n && m1_n && (!rd_n || !wr_n) && match_hit;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      rd_d    = rd_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               idx_d   = match_idx;
               rd_d    = !rd_n;
               cnt_d   = wait_arr[match_idx];
               state_d = (wait_arr[match_idx] != '0) ? StWait : StStrobe;
            end
         end
         StWait: begin
            if (iorq_n) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else if (ce_3m58) begin
               cnt_d = cnt_q - WAIT_W'(1);
               if (cnt_q == WAIT_W'(1)) begin
                  state_d = StStrobe;
               end
            end
         end
         StStrobe: begin
            state_d = rd_q ? StData : StHold;
         end
         StData: begin
            // Device sees its strobe one cycle earlier, so data is valid here.
            rdata_d = rdat_arr[idx_q];
            state_d = StHold;
         end
         StHold: begin
            if (iorq_n) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk21m) begin
      if (reset) begin
         state_q <= StIdle;
         idx_q   <= '0;
         rd_q    <= 1'b0;
         cnt_q   <= '0;
         rdata_q <= IO_IDLE_DATA;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         rd_q    <= rd_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
      end
   end

   always_comb begin
      dev_cs_rd = '0;
      dev_cs_wr = '0;
      if (state_q == StStrobe) begin
         if (rd_q) begin
            dev_cs_rd[idx_q] = 1'b1;
         end else begin
            dev_cs_wr[idx_q] = 1'b1;
         end
      end
   end

   assign wait_n    = !((state_q == StWait) || (state_q == StStrobe) || (state_q == StData));
   assign drive_rd  = (state_q == StHold) && rd_q && !rd_n;
   assign dataBusRQ = drive_rd;
   assign d_to_cpu  = drive_rd ? rdata_q : IO_IDLE_DATA;
   assign dev_wdata = d_from_cpu;

`ifdef MSX_IO_CONFLICT_EN
   logic       conflict_q;
   logic [7:0] conflict_cnt_q;
   logic [7:0] conflict_cnt;

   always_ff @(posedge clk21m) begin
      if (reset) begin
         conflict_q     <= 1'b0;
         conflict_cnt_q <= 8'h00;
      end else if (start && match_multi) begin
         conflict_q <= 1'b1;
         if (conflict_cnt_q != 8'hFF) begin
            conflict_cnt_q <= conflict_cnt_q + 8'd1;
         end
      end
   end

   assign conflict     = conflict_q;
   assign conflict_cnt = conflict_cnt_q;
`else
   logic unused_multi;
   assign unused_multi = match_multi;
   assign conflict     = 1'b0;
`endif

endmodule

// File: tb/tb_msx_io_bus.sv
// Bench for msx_io_bus: vector table of CPU I/O cycles plus strobe scoreboard.
module tb_msx_io_bus;

   localparam int NUM_DEV = 4;
   localparam int WAIT_W  = 4;

   logic                      clk21m = 1'b0;
   logic                      reset  = 1'b1;
   logic                      ce_3m58 = 1'b0;
   logic [7:0]                addr = 8'h00;
   logic [7:0]                d_from_cpu = 8'h00;
   logic                      wr_n = 1'b1;
   logic                      rd_n = 1'b1;
   logic                      iorq_n = 1'b1;
   logic                      m1_n = 1'b1;
   logic [NUM_DEV*8-1:0]      dev_base;
   logic [NUM_DEV*8-1:0]      dev_mask;
   logic [NUM_DEV*WAIT_W-1:0] dev_wait;
   logic [NUM_DEV*8-1:0]      dev_rd_data;
   logic [NUM_DEV-1:0]        dev_cs_rd;
   logic [NUM_DEV-1:0]        dev_cs_wr;
   logic [7:0]                dev_wdata;
   logic [7:0]                d_to_cpu;
   logic                      dataBusRQ;
   logic                      wait_n;
   logic                      conflict;

   logic [7:0] base_a [NUM_DEV];
   logic [7:0] mask_a [NUM_DEV];
   logic [7:0] rdat_a [NUM_DEV];
   int         wait_a [NUM_DEV];

   typedef struct {
      logic [7:0] addr;
      bit         rd;
      logic [7:0] wdata;
      bit         m1_n;
      bit         hit;
      int         dev;
      logic [7:0] rdata;
      bit         multi;
   } vec_t;

   typedef struct {
      logic [NUM_DEV-1:0] cs_rd;
      logic [NUM_DEV-1:0] cs_wr;
      logic [7:0]         wdata;
   } sb_t;

   sb_t  sb_q[$];
   sb_t  sb_pop;
   vec_t vecs[13];
   int   total = 0;
   int   bad = 0;
   int   multi_seen = 0;
   int   ce_div = 0;

   msx_io_bus #(
      .NUM_DEV (NUM_DEV),
      .WAIT_W  (WAIT_W)
   ) dut (
      .clk21m      (clk21m),
      .reset       (reset),
      .ce_3m58     (ce_3m58),
      .addr        (addr),
      .d_from_cpu  (d_from_cpu),
      .wr_n        (wr_n),
      .rd_n        (rd_n),
      .iorq_n      (iorq_n),
      .m1_n        (m1_n),
      .dev_base    (dev_base),
      .dev_mask    (dev_mask),
      .dev_wait    (dev_wait),
      .dev_rd_data (dev_rd_data),
      .dev_cs_rd   (dev_cs_rd),
      .dev_cs_wr   (dev_cs_wr),
      .dev_wdata   (dev_wdata),
      .d_to_cpu    (d_to_cpu),
      .dataBusRQ   (dataBusRQ),
      .wait_n      (wait_n),
      .conflict    (conflict)
   );

   always #5 clk21m = ~clk21m;

   // CPU enable every 6th clock, changed just after the rising edge.
   always begin
      @(posedge clk21m);
      #2;
      ce_div  = (ce_div + 1) % 6;
      ce_3m58 = (ce_div == 0);
   end

   always_comb begin
      for (int i = 0; i < NUM_DEV; i++) begin
         dev_base[8*i +: 8]           = base_a[i];
         dev_mask[8*i +: 8]           = mask_a[i];
         dev_rd_data[8*i +: 8]        = rdat_a[i];
         dev_wait[WAIT_W*i +: WAIT_W] = 4'(wait_a[i]);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Every strobe must be one-hot and match the oldest expected access.
   always @(negedge clk21m) begin
      if (!reset && ((|dev_cs_rd) || (|dev_cs_wr))) begin
         chk("strobe_onehot", 32'($onehot({dev_cs_rd, dev_cs_wr})), 32'd1);
         if (sb_q.size() == 0) begin
            chk("stray_strobe", 32'({dev_cs_rd, dev_cs_wr}), 32'h0);
         end else begin
            sb_pop = sb_q.pop_front();
            chk("strobe_rd", 32'(dev_cs_rd), 32'(sb_pop.cs_rd));
            chk("strobe_wr", 32'(dev_cs_wr), 32'(sb_pop.cs_wr));
            if (|sb_pop.cs_wr) chk("strobe_wdata", 32'(dev_wdata), 32'(sb_pop.wdata));
         end
      end
   end

   task automatic chk_conflict(input string name);
`ifdef MSX_IO_CONFLICT_EN
      chk($sformatf("%s/conflict", name), 32'(conflict), 32'(multi_seen > 0));
      chk($sformatf("%s/conflict_cnt", name), 32'(dut.conflict_cnt), 32'(multi_seen));
`else
      chk($sformatf("%s/conflict", name), 32'(conflict), 32'd0);
`endif
   endtask

   task automatic run_vec(input vec_t v, input string name);
      int   low;
      int   strobe_at;
      int   ces;
      int   trail;
      int   w;
      bit   done;
      bit   ce_h [64];
      sb_t  e;
      w     = wait_a[v.dev];
      trail = v.rd ? 2 : 1;
      @(negedge clk21m);
      addr       = v.addr;
      d_from_cpu = v.wdata;
      m1_n       = v.m1_n;
      iorq_n     = 1'b0;
      rd_n       = !v.rd;
      wr_n       = v.rd;
      if (v.hit) begin
         e.cs_rd = '0;
         e.cs_wr = '0;
         e.wdata = v.wdata;
         if (v.rd) e.cs_rd[v.dev] = 1'b1;
         else e.cs_wr[v.dev] = 1'b1;
         sb_q.push_back(e);
      end
      low = 0;
      strobe_at = -1;
      done = 1'b0;
      for (int k = 1; k <= 60 && !done; k++) begin
         @(negedge clk21m);
         if (!wait_n) begin
            if (low < 64) ce_h[low] = ce_3m58;
            low++;
         end
         if ((|dev_cs_rd) || (|dev_cs_wr)) strobe_at = k;
         if (k >= 4 && wait_n) done = 1'b1;
      end
      chk($sformatf("%s/cycle_done", name), 32'(done), 32'd1);
      chk($sformatf("%s/hold_data", name), 32'(d_to_cpu),
          (v.hit && v.rd) ? 32'(v.rdata) : 32'hFF);
      chk($sformatf("%s/hold_rq", name), 32'(dataBusRQ), 32'(v.hit && v.rd));
      chk($sformatf("%s/strobe_cycle", name), 32'(strobe_at),
          v.hit ? 32'(low - trail + 1) : 32'hFFFF_FFFF);
      if (!v.hit) begin
         chk($sformatf("%s/wait_low", name), 32'(low), 32'd0);
      end else if (w == 0) begin
         chk($sformatf("%s/wait_low", name), 32'(low), 32'(trail));
      end else if (low > trail && low <= 64) begin
         ces = 0;
         for (int i = 0; i < low - trail; i++) ces += int'(ce_h[i]);
         chk($sformatf("%s/wait_ticks", name), 32'(ces), 32'(w));
         chk($sformatf("%s/last_tick", name), 32'(ce_h[low-trail-1]), 32'd1);
      end else begin
         chk($sformatf("%s/wait_low", name), 32'(low), 32'(trail + 1));
      end
      if (v.hit && v.rd) begin
         rd_n = 1'b1;
         @(negedge clk21m);
         chk($sformatf("%s/rd_release_data", name), 32'(d_to_cpu), 32'hFF);
         chk($sformatf("%s/rd_release_rq", name), 32'(dataBusRQ), 32'd0);
      end
      iorq_n = 1'b1;
      rd_n   = 1'b1;
      wr_n   = 1'b1;
      m1_n   = 1'b1;
      @(negedge clk21m);
      chk($sformatf("%s/idle_wait_n", name), 32'(wait_n), 32'd1);
      chk($sformatf("%s/idle_data", name), 32'(d_to_cpu), 32'hFF);
      if (v.hit && v.multi) multi_seen++;
      chk_conflict(name);
   endtask

   initial begin
      #200_000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1);
   end

   initial begin
      base_a[0] = 8'h98; mask_a[0] = 8'hF8; wait_a[0] = 0; rdat_a[0] = 8'h5A;
      base_a[1] = 8'hA0; mask_a[1] = 8'hFE; wait_a[1] = 3; rdat_a[1] = 8'h11;
      base_a[2] = 8'hB0; mask_a[2] = 8'hF0; wait_a[2] = 1; rdat_a[2] = 8'h77;
      base_a[3] = 8'h38; mask_a[3] = 8'h38; wait_a[3] = 2; rdat_a[3] = 8'hE1;

      //          addr   rd wdata  m1 hit dev rdata  multi
      vecs[0]  = '{8'h99, 1, 8'h00, 1, 1, 0, 8'h5A, 0};
      vecs[1]  = '{8'hA1, 0, 8'h3C, 1, 1, 1, 8'hFF, 0};
      vecs[2]  = '{8'h10, 1, 8'h00, 1, 0, 0, 8'hFF, 0};
      vecs[3]  = '{8'h99, 1, 8'h00, 0, 0, 0, 8'hFF, 0};
      vecs[4]  = '{8'hA0, 1, 8'h00, 1, 1, 1, 8'h11, 0};
      vecs[5]  = '{8'h9F, 0, 8'hC3, 1, 1, 0, 8'hFF, 0};
      vecs[6]  = '{8'hB9, 1, 8'h00, 1, 1, 2, 8'h77, 1};
      vecs[7]  = '{8'hB4, 1, 8'h00, 1, 1, 2, 8'h77, 0};
      vecs[8]  = '{8'hBA, 0, 8'h55, 1, 1, 2, 8'hFF, 1};
      vecs[9]  = '{8'h7C, 1, 8'h00, 1, 1, 3, 8'hE1, 0};
      vecs[10] = '{8'hC0, 0, 8'h12, 1, 0, 0, 8'hFF, 0};
      vecs[11] = '{8'hF8, 1, 8'h00, 0, 0, 0, 8'hFF, 0};
      vecs[12] = '{8'h3F, 0, 8'h9A, 1, 1, 3, 8'hFF, 0};

      repeat (3) @(negedge clk21m);
      chk("reset/wait_n", 32'(wait_n), 32'd1);
      chk("reset/cs", 32'({dev_cs_rd, dev_cs_wr}), 32'd0);
      chk("reset/d_to_cpu", 32'(d_to_cpu), 32'hFF);
      chk("reset/rq", 32'(dataBusRQ), 32'd0);
      chk("reset/conflict", 32'(conflict), 32'd0);
      reset = 1'b0;
      @(negedge clk21m);

      for (int i = 0; i < 13; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Overlap at 98h: dev2 and dev3 both match, dev0 moved out of the way.
      base_a[0] = 8'h00; mask_a[0] = 8'hFF;
      base_a[2] = 8'h90; mask_a[2] = 8'hF0;
      base_a[3] = 8'h98; mask_a[3] = 8'hFF;
      run_vec('{8'h98, 1, 8'h00, 1, 1, 2, 8'h77, 1}, "overlap98");
      base_a[0] = 8'h98; mask_a[0] = 8'hF8;
      base_a[2] = 8'hB0; mask_a[2] = 8'hF0;
      base_a[3] = 8'h38; mask_a[3] = 8'h38;

      // Early abort: iorq_n released while dev1 is still in wait states.
      @(negedge clk21m);
      addr = 8'hA1; d_from_cpu = 8'h3C; iorq_n = 1'b0; wr_n = 1'b0;
      repeat (2) @(negedge clk21m);
      chk("abort/wait_low", 32'(wait_n), 32'd0);
      iorq_n = 1'b1; wr_n = 1'b1;
      @(negedge clk21m);
      chk("abort/wait_release", 32'(wait_n), 32'd1);
      repeat (20) @(negedge clk21m);
      chk("abort/idle_data", 32'(d_to_cpu), 32'hFF);

      // Reset asserted in the middle of a waited read.
      addr = 8'hA0; iorq_n = 1'b0; rd_n = 1'b0;
      repeat (2) @(negedge clk21m);
      chk("rstmid/wait_low", 32'(wait_n), 32'd0);
      reset = 1'b1;
      @(negedge clk21m);
      chk("rstmid/wait_n", 32'(wait_n), 32'd1);
      chk("rstmid/cs", 32'({dev_cs_rd, dev_cs_wr}), 32'd0);
      chk("rstmid/d_to_cpu", 32'(d_to_cpu), 32'hFF);
      chk("rstmid/rq", 32'(dataBusRQ), 32'd0);
      iorq_n = 1'b1; rd_n = 1'b1;
      @(negedge clk21m);
      reset = 1'b0;
      multi_seen = 0;
      @(negedge clk21m);
      chk_conflict("rstmid");
      run_vec(vecs[0], "after_reset_rd");
      run_vec(vecs[1], "after_reset_wr");

      repeat (4) @(negedge clk21m);
      chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
